// File: rtl/cdf_accumulator.sv
// cdf_accumulator
// Converts a completed histogram held in an external scratch memory into its
// cumulative distribution, in place. Each bin is read and added to a running
// accumulator, and the running sum is written back to the same bin.
//
// Ports
//   clock            rising-edge system clock
//   reset            synchronous, active-high reset
//   start_cdf        one-cycle pulse; the histogram is complete (accepted in IDLE only)
//   scratch_rd_addr  read address, equal to the current bin index
//   scratch_rd_data  read data, valid RD_LATENCY clocks after the address
//   scratch_wr_addr  write address (current bin index)
//   scratch_wr_data  CDF value for the current bin
//   scratch_we       write strobe, one cycle per bin
//   cdf_busy         high from the cycle after start up to and including DONE
//   cdf_done         one-cycle pulse once every bin has been rewritten
//   cdf_min          first non-zero CDF value (equalisation offset)
//   cdf_total        final CDF value (total pixel count)
//
// Build option: define CDF_SATURATE_EN to make the accumulator saturate at
// 2^COUNT_W-1. Without it the accumulator wraps modulo 2^COUNT_W.
//
// state  | meaning
// IDLE   | waiting for start_cdf
// SET_RD | present bin index to the scratch memory, load read-wait counter
// WAIT   | count down the remaining read latency
// ACC    | add read data into the accumulator, capture cdf_min
// WRITE  | write accumulator back to the current bin
// NEXT   | advance to the next bin or finish
// DONE   | pulse cdf_done, latch cdf_total
module cdf_accumulator #(
   parameter int BIN_COUNT  = 256,
   parameter int ADDR_W     = 8,
   parameter int COUNT_W    = 16,
   parameter int RD_LATENCY = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start_cdf,
   output logic [ADDR_W-1:0]  scratch_rd_addr,
   input  logic [COUNT_W-1:0] scratch_rd_data,
   output logic [ADDR_W-1:0]  scratch_wr_addr,
   output logic [COUNT_W-1:0] scratch_wr_data,
   output logic               scratch_we,
   output logic               cdf_busy,
   output logic               cdf_done,
   output logic [COUNT_W-1:0] cdf_min,
   output logic [COUNT_W-1:0] cdf_total
);

   localparam int CNT_W = $clog2(RD_LATENCY + 1);

   typedef enum logic [2:0] {
      IDLE,
      SET_RD,
      WAIT,
      ACC,
      WRITE,
      NEXT,
      DONE
   } state_t;

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  bin_idx;
   logic [CNT_W-1:0]   wait_cnt;
   logic [COUNT_W-1:0] acc;
   logic [COUNT_W-1:0] acc_sum;
   logic               last_bin;

`ifdef CDF_SATURATE_EN
   logic [COUNT_W:0] sum_full;
   assign sum_full = {1'b0, acc} + {1'b0, scratch_rd_data};
   assign acc_sum  = sum_full[COUNT_W] ? {COUNT_W{1'b1}} : sum_full[COUNT_W-1:0];
`else
   assign acc_sum  = acc + scratch_rd_data;
`endif

   assign last_bin = (bin_idx == ADDR_W'(BIN_COUNT - 1));

   // The bin index only changes in IDLE and NEXT, so the read address is
   // stable from one SET_RD until the next.
   assign scratch_rd_addr = bin_idx;
   assign scratch_wr_addr = bin_idx;
   assign scratch_wr_data = acc;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         bin_idx   <= '0;
         wait_cnt  <= '0;
         acc       <= '0;
         cdf_min   <= '0;
         cdf_total <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start_cdf) begin
                  bin_idx <= '0;
                  acc     <= '0;
                  cdf_min <= '0;
               end
            end
            SET_RD: wait_cnt <= CNT_W'(RD_LATENCY - 1);
            WAIT:   wait_cnt <= wait_cnt - 1'b1;
            ACC: begin
               acc <= acc_sum;
               if (cdf_min == '0 && acc_sum != '0)
                  cdf_min <= acc_sum;
            end
            NEXT: begin
               if (!last_bin)
                  bin_idx <= bin_idx + 1'b1;
            end
            DONE:   cdf_total <= acc;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      scratch_we = 1'b0;
      cdf_done   = 1'b0;
      cdf_busy   = (state != IDLE);
      case (state)
         IDLE:   if (start_cdf) state_nxt = SET_RD;
         SET_RD: state_nxt = (RD_LATENCY == 1) ? ACC : WAIT;
         // Counter holds 1 on the last WAIT cycle; ACC then lands exactly
         // RD_LATENCY clocks after SET_RD.
         WAIT:   if (wait_cnt <= CNT_W'(1)) state_nxt = ACC;
         ACC:    state_nxt = WRITE;
         WRITE: begin
            scratch_we = 1'b1;
            state_nxt  = NEXT;
         end
         NEXT:   state_nxt = last_bin ? DONE : SET_RD;
         DONE: begin
            cdf_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cdf_accumulator.sv
module tb_cdf_accumulator;

   localparam int BIN_COUNT  = 256;
   localparam int ADDR_W     = 8;
   localparam int COUNT_W    = 16;
   localparam int RD_LATENCY = 3;
   localparam int EXP_LAT    = 1 + BIN_COUNT * (RD_LATENCY + 3);

   logic               clock = 1'b0;
   logic               reset;
   logic               start_cdf;
   logic [ADDR_W-1:0]  scratch_rd_addr;
   logic [COUNT_W-1:0] scratch_rd_data;
   logic [ADDR_W-1:0]  scratch_wr_addr;
   logic [COUNT_W-1:0] scratch_wr_data;
   logic               scratch_we;
   logic               cdf_busy;
   logic               cdf_done;
   logic [COUNT_W-1:0] cdf_min;
   logic [COUNT_W-1:0] cdf_total;

   cdf_accumulator #(
      .BIN_COUNT(BIN_COUNT), .ADDR_W(ADDR_W), .COUNT_W(COUNT_W), .RD_LATENCY(RD_LATENCY)
   ) dut (
      .clock(clock), .reset(reset), .start_cdf(start_cdf),
      .scratch_rd_addr(scratch_rd_addr), .scratch_rd_data(scratch_rd_data),
      .scratch_wr_addr(scratch_wr_addr), .scratch_wr_data(scratch_wr_data),
      .scratch_we(scratch_we), .cdf_busy(cdf_busy), .cdf_done(cdf_done),
      .cdf_min(cdf_min), .cdf_total(cdf_total)
   );

   always #5 clock = ~clock;

   // Scratch memory with RD_LATENCY-deep read pipeline
   logic [COUNT_W-1:0] mem [BIN_COUNT];
   logic [COUNT_W-1:0] pipe [RD_LATENCY];
   int wr_count;
   int order_err;
   int exp_addr;
   int done_count;

   always @(posedge clock) begin
      pipe[0] <= mem[scratch_rd_addr];
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      if (scratch_we) begin
         mem[scratch_wr_addr] = scratch_wr_data;
         if (int'(scratch_wr_addr) != exp_addr) order_err = order_err + 1;
         exp_addr = exp_addr + 1;
         wr_count = wr_count + 1;
      end
   end
   assign scratch_rd_data = pipe[RD_LATENCY-1];

   always @(negedge clock) if (cdf_done) done_count = done_count + 1;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [COUNT_W-1:0] v);
      for (int i = 0; i < BIN_COUNT; i++) mem[i] = v;
   endtask

   task automatic clr_mon();
      wr_count = 0; order_err = 0; exp_addr = 0; done_count = 0;
   endtask

   // Start pulse, then count cycles until cdf_done. lat = 1537 means done
   // appeared 1537 clocks after the start cycle.
   task automatic run_cdf(input int repulse_at, output int lat);
      int n;
      clr_mon();
      start_cdf = 1'b1;
      @(negedge clock);
      start_cdf = 1'b0;
      n = 1;
      chk("busy_after_start", {31'b0, cdf_busy}, 32'd1);
      while (!cdf_done && n < 3000) begin
         start_cdf = (n == repulse_at);
         @(negedge clock);
         n++;
      end
      start_cdf = 1'b0;
      lat = cdf_done ? n : -1;
      repeat (5) @(negedge clock);
   endtask

   initial begin
      int lat;
      int n;
      reset = 1'b1;
      start_cdf = 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] = '0;
      fill('0);
      clr_mon();
      repeat (3) @(negedge clock);
      chk("rst_busy", {31'b0, cdf_busy}, 32'd0);
      chk("rst_done", {31'b0, cdf_done}, 32'd0);
      chk("rst_we", {31'b0, scratch_we}, 32'd0);
      chk("rst_min", {16'b0, cdf_min}, 32'd0);
      chk("rst_total", {16'b0, cdf_total}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // All bins = 1
      fill(16'd1);
      run_cdf(-1, lat);
      chk("ones_latency", lat, EXP_LAT);
      chk("ones_writes", wr_count, 256);
      chk("ones_order", order_err, 0);
      chk("ones_done_cnt", done_count, 1);
      chk("ones_bin0", {16'b0, mem[0]}, 32'd1);
      chk("ones_bin100", {16'b0, mem[100]}, 32'd101);
      chk("ones_bin255", {16'b0, mem[255]}, 32'd256);
      chk("ones_min", {16'b0, cdf_min}, 32'd1);
      chk("ones_total", {16'b0, cdf_total}, 32'd256);
      chk("ones_idle_busy", {31'b0, cdf_busy}, 32'd0);
      repeat (10) @(negedge clock);
      chk("ones_min_hold", {16'b0, cdf_min}, 32'd1);
      chk("ones_total_hold", {16'b0, cdf_total}, 32'd256);

      // Only bin 10 = 500, with start re-pulsed mid-run
      fill('0);
      mem[10] = 16'd500;
      run_cdf(100, lat);
      chk("b10_latency", lat, EXP_LAT);
      chk("b10_writes", wr_count, 256);
      chk("b10_done_cnt", done_count, 1);
      chk("b10_bin9", {16'b0, mem[9]}, 32'd0);
      chk("b10_bin10", {16'b0, mem[10]}, 32'd500);
      chk("b10_bin255", {16'b0, mem[255]}, 32'd500);
      chk("b10_min", {16'b0, cdf_min}, 32'd500);
      chk("b10_total", {16'b0, cdf_total}, 32'd500);

      // Overflow on bin 1
      fill('0);
      mem[0] = 16'hFFF0;
      mem[1] = 16'hFFF0;
      run_cdf(-1, lat);
      chk("ovf_bin0", {16'b0, mem[0]}, 32'hFFF0);
      chk("ovf_min", {16'b0, cdf_min}, 32'hFFF0);
`ifdef CDF_SATURATE_EN
      chk("ovf_bin1", {16'b0, mem[1]}, 32'hFFFF);
      chk("ovf_total", {16'b0, cdf_total}, 32'hFFFF);
`else
      chk("ovf_bin1", {16'b0, mem[1]}, 32'hFFE0);
      chk("ovf_total", {16'b0, cdf_total}, 32'hFFE0);
`endif

      // Reset 20 clocks into a run: bins 0..2 written (cycles 5, 11, 17)
      fill(16'd1);
      clr_mon();
      start_cdf = 1'b1;
      @(negedge clock);
      start_cdf = 1'b0;
      n = 1;
      while (n < 20) begin
         @(negedge clock);
         n++;
      end
      reset = 1'b1;
      @(negedge clock);
      chk("abort_busy", {31'b0, cdf_busy}, 32'd0);
      chk("abort_we", {31'b0, scratch_we}, 32'd0);
      chk("abort_total", {16'b0, cdf_total}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (30) @(negedge clock);
      chk("abort_writes", wr_count, 3);
      chk("abort_done_cnt", done_count, 0);
      chk("abort_bin2", {16'b0, mem[2]}, 32'd3);
      chk("abort_bin3", {16'b0, mem[3]}, 32'd1);
      fill(16'd1);
      run_cdf(-1, lat);
      chk("fresh_latency", lat, EXP_LAT);
      chk("fresh_writes", wr_count, 256);
      chk("fresh_total", {16'b0, cdf_total}, 32'd256);

      // All-zero histogram
      fill(16'd7);
      for (int i = 0; i < BIN_COUNT; i++) mem[i] = '0;
      run_cdf(-1, lat);
      chk("zero_latency", lat, EXP_LAT);
      chk("zero_writes", wr_count, 256);
      chk("zero_done_cnt", done_count, 1);
      chk("zero_bin255", {16'b0, mem[255]}, 32'd0);
      chk("zero_min", {16'b0, cdf_min}, 32'd0);
      chk("zero_total", {16'b0, cdf_total}, 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
